// File: rtl/lcd_write_arbiter.sv
// LCD bus sequencer: power-up init, then round-robin single-byte writes from ports A/B; LCD_LONG_CMD_EN stretches clear/home waits.
// Ready is combinational in IDLE (capture on the same edge); each write spans SETUP+E_TICKS+HOLD+WAIT ticks, requests wait while busy.
module lcd_write_arbiter #(
   parameter int CLK_DIV    = 5,
   parameter int PWR_TICKS  = 70,
   parameter int E_TICKS    = 2,
   parameter int WAIT_SHORT = 4,
   parameter int WAIT_LONG  = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_valid,
   input  logic       a_rs,
   input  logic [7:0] a_data,
   output logic       a_ready,
   input  logic       b_valid,
   input  logic       b_rs,
   input  logic [7:0] b_data,
   output logic       b_ready,
   output logic       init_done,
   output logic       busy,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data
);

   typedef enum logic [3:0] {
      PWR_WAIT, INIT_SETUP, INIT_PULSE, INIT_HOLD, INIT_WAIT,
      IDLE, SETUP, PULSE, HOLD, WAIT
   } state_t;

   localparam int T1   = (PWR_TICKS > WAIT_LONG) ? PWR_TICKS : WAIT_LONG;
   localparam int T2   = (E_TICKS > WAIT_SHORT) ? E_TICKS : WAIT_SHORT;
   localparam int TMAX = (T1 > T2) ? T1 : T2;
   localparam int CW   = $clog2(TMAX + 1);
   localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [CW-1:0]   tcnt_q, tcnt_d;
   logic [CW-1:0]   dur_m1;
   logic [1:0]      init_idx_q, init_idx_d;
   logic            init_done_q, init_done_d;
   logic            last_grant_q, last_grant_d;   // 1 = B was granted last
   logic            rs_q, rs_d;
   logic [7:0]      data_q, data_d;
   logic            tick;
   logic            wait_long;
   logic            grant_a, grant_b;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   assign tick = (presc_q == PW'(CLK_DIV - 1));

`ifdef LCD_LONG_CMD_EN
   assign wait_long = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
`else
   assign wait_long = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= PWR_WAIT;
         presc_q      <= '0;
         tcnt_q       <= '0;
         init_idx_q   <= '0;
         init_done_q  <= 1'b0;
         last_grant_q <= 1'b1;
         rs_q         <= 1'b0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         tcnt_q       <= tcnt_d;
         init_idx_q   <= init_idx_d;
         init_done_q  <= init_done_d;
         last_grant_q <= last_grant_d;
         rs_q         <= rs_d;
         data_q       <= data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      presc_d      = tick ? '0 : presc_q + PW'(1);
      tcnt_d       = tcnt_q;
      init_idx_d   = init_idx_q;
      init_done_d  = init_done_q;
      last_grant_d = last_grant_q;
      rs_d         = rs_q;
      data_d       = data_q;

      case (state_q)
         PWR_WAIT:               dur_m1 = CW'(PWR_TICKS - 1);
         INIT_PULSE, PULSE:      dur_m1 = CW'(E_TICKS - 1);
         INIT_WAIT, WAIT:        dur_m1 = wait_long ? CW'(WAIT_LONG - 1) : CW'(WAIT_SHORT - 1);
         default:                dur_m1 = '0;
      endcase

      if (state_q == IDLE) begin
         if (grant_a) begin
            state_d      = SETUP;
            rs_d         = a_rs;
            data_d       = a_data;
            last_grant_d = 1'b0;
         end else if (grant_b) begin
            state_d      = SETUP;
            rs_d         = b_rs;
            data_d       = b_data;
            last_grant_d = 1'b1;
         end
      end else if (tick) begin
         if (tcnt_q != dur_m1) begin
            tcnt_d = tcnt_q + CW'(1);
         end else begin
            tcnt_d = '0;
            case (state_q)
               PWR_WAIT: begin
                  state_d = INIT_SETUP;
                  rs_d    = 1'b0;
                  data_d  = init_cmd(init_idx_q);
               end
               INIT_SETUP: state_d = INIT_PULSE;
               INIT_PULSE: state_d = INIT_HOLD;
               INIT_HOLD:  state_d = INIT_WAIT;
               INIT_WAIT: begin
                  if (init_idx_q == 2'd3) begin
                     state_d     = IDLE;
                     init_done_d = 1'b1;
                  end else begin
                     state_d    = INIT_SETUP;
                     init_idx_d = init_idx_q + 2'd1;
                     data_d     = init_cmd(init_idx_q + 2'd1);
                  end
               end
               SETUP:   state_d = PULSE;
               PULSE:   state_d = HOLD;
               HOLD:    state_d = WAIT;
               WAIT:    state_d = IDLE;
               default: state_d = PWR_WAIT;
            endcase
         end
      end
   end

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state_q == IDLE) begin
         grant_a = a_valid && (!b_valid || last_grant_q);
         grant_b = b_valid && !grant_a;
      end
      a_ready   = grant_a;
      b_ready   = grant_b;
      lcd_e     = (state_q == INIT_PULSE) || (state_q == PULSE);
      busy      = !((state_q == IDLE) && init_done_q);
      init_done = init_done_q;
      lcd_rs    = rs_q;
      lcd_data  = data_q;
      lcd_rw    = 1'b0;
   end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomised bench for lcd_write_arbiter against a tick-count model of the LCD write timeline.
`timescale 1ns/1ps
module tb_lcd_write_arbiter;

   localparam int CLK_DIV    = 2;
   localparam int PWR_TICKS  = 70;
   localparam int E_TICKS    = 2;
   localparam int WAIT_SHORT = 4;
   localparam int WAIT_LONG  = 40;
`ifdef LCD_LONG_CMD_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       a_valid = 1'b0, a_rs = 1'b0, b_valid = 1'b0, b_rs = 1'b0;
   logic [7:0] a_data = 8'h00, b_data = 8'h00;
   logic       a_ready, b_ready, init_done, busy, lcd_e, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;

   int n_tests = 0;
   int n_fail  = 0;

   lcd_write_arbiter #(
      .CLK_DIV(CLK_DIV), .PWR_TICKS(PWR_TICKS), .E_TICKS(E_TICKS),
      .WAIT_SHORT(WAIT_SHORT), .WAIT_LONG(WAIT_LONG)
   ) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_rs(a_rs), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_rs(b_rs), .b_data(b_data), .b_ready(b_ready),
      .init_done(init_done), .busy(busy),
      .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a write is one tick-count window; e is high for ticks 1..E_TICKS of it.
   typedef enum {M_PWR, M_WR, M_IDLE} mmode_t;
   mmode_t     m_mode = M_PWR;
   int         m_el = 0;
   int         m_n = 0;
   int         m_init_i = 0;
   bit         m_init_done = 1'b0;
   bit         m_last_b = 1'b1;
   bit         m_tick;
   logic       m_rs = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

   function automatic int wait_len(input logic rs, input logic [7:0] d);
      if (LONG_EN && !rs && (d == 8'h01 || d == 8'h02)) return WAIT_LONG;
      return WAIT_SHORT;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_mode = M_PWR; m_el = 0; m_n = 0; m_init_i = 0;
         m_init_done = 1'b0; m_last_b = 1'b1; m_rs = 1'b0; m_data = 8'h00;
      end else begin
         m_tick = (m_n % CLK_DIV) == (CLK_DIV - 1);
         m_n++;
         case (m_mode)
            M_PWR: if (m_tick) begin
               m_el++;
               if (m_el == PWR_TICKS) begin
                  m_mode = M_WR; m_el = 0; m_init_i = 0;
                  m_rs = 1'b0; m_data = init_tab[0];
               end
            end
            M_WR: if (m_tick) begin
               m_el++;
               if (m_el == 2 + E_TICKS + wait_len(m_rs, m_data)) begin
                  m_el = 0;
                  if (m_init_done) m_mode = M_IDLE;
                  else if (m_init_i == 3) begin
                     m_init_done = 1'b1; m_mode = M_IDLE;
                  end else begin
                     m_init_i++; m_data = init_tab[m_init_i];
                  end
               end
            end
            default: begin
               if (a_valid && (!b_valid || m_last_b)) begin
                  m_mode = M_WR; m_el = 0; m_rs = a_rs; m_data = a_data; m_last_b = 1'b0;
               end else if (b_valid) begin
                  m_mode = M_WR; m_el = 0; m_rs = b_rs; m_data = b_data; m_last_b = 1'b1;
               end
            end
         endcase
      end
   end

   bit exp_ga, exp_gb;
   initial forever begin
      @(negedge clk);
      exp_ga = (m_mode == M_IDLE) && a_valid && (!b_valid || m_last_b);
      exp_gb = (m_mode == M_IDLE) && b_valid && !exp_ga;
      check("lcd_e", lcd_e, (m_mode == M_WR) && (m_el >= 1) && (m_el <= E_TICKS));
      check("lcd_rs", lcd_rs, m_rs);
      check("lcd_data", lcd_data, m_data);
      check("lcd_rw", lcd_rw, 0);
      check("init_done", init_done, m_init_done);
      check("busy", busy, !((m_mode == M_IDLE) && m_init_done));
      check("a_ready", a_ready, exp_ga);
      check("b_ready", b_ready, exp_gb);
   end

   bit a_seen = 1'b0, b_seen = 1'b0;
   int glog [$];
   initial forever begin
      @(negedge clk);
      a_seen = a_ready;
      b_seen = b_ready;
      if (a_ready) glog.push_back(0);
      if (b_ready) glog.push_back(1);
   end

   function automatic bit cond(input int sel);
      case (sel)
         0:       return lcd_e;
         1:       return init_done;
         2:       return !busy;
         default: return a_ready;
      endcase
   endfunction

   task automatic wait_for(input int sel, input string tag);
      int g = 0;
      do begin @(negedge clk); g++; end while (!cond(sel) && g < 5000);
      if (!cond(sel)) begin
         n_tests++; n_fail++;
         $display("FAIL %s: timed out, condition not reached", tag);
      end
   endtask

   task automatic e_width_check(input string tag);
      int w = 0;
      while (lcd_e && w < 100) begin w++; @(negedge clk); end
      check(tag, w, E_TICKS * CLK_DIV);
   endtask

   task automatic a_write(input logic rs, input logic [7:0] d, input int exp_wait_clks);
      int c = 0;
      wait_for(2, "idle_before_write");
      @(posedge clk); #1; a_valid = 1'b1; a_rs = rs; a_data = d;
      wait_for(3, "a_ready");
      @(posedge clk); #1; a_valid = 1'b0;
      wait_for(0, "write_e_rise");
      check("write_rs", lcd_rs, rs);
      check("write_data", lcd_data, d);
      e_width_check("write_e_width");
      while (busy && c < 1000) begin @(negedge clk); c++; end
      check("hold_wait_clks", c, exp_wait_clks);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      b_valid = 1'b1; b_rs = 1'b1; b_data = 8'h2B;
      #2 rst = 1'b1;

      // power wait, then the four init commands
      wait_for(0, "first_e_rise");
      check("pwr_wait_clks", m_n, (PWR_TICKS + 1) * CLK_DIV);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) wait_for(0, "init_e_rise");
         check("init_data", lcd_data, init_tab[i]);
         check("init_rs", lcd_rs, 0);
         e_width_check("init_e_width");
      end
      wait_for(1, "init_done");
      check("init_done_clks", m_n, LONG_EN ? 276 : 204);
      check("b_ready_at_init_done", b_ready, 1);
      @(posedge clk); #1; b_valid = 1'b0;

      a_write(1'b1, 8'h35, (1 + WAIT_SHORT) * CLK_DIV);

      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         if (a_valid && a_seen) a_valid = 1'b0;
         else if (a_valid && $urandom_range(0, 19) == 0) a_valid = 1'b0;
         if (b_valid && b_seen) b_valid = 1'b0;
         else if (b_valid && $urandom_range(0, 19) == 0) b_valid = 1'b0;
         if (!a_valid && $urandom_range(0, 3) == 0) begin
            a_valid = 1'b1; a_rs = 1'($urandom_range(0, 1)); a_data = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin a_rs = 1'b0; a_data = 8'($urandom_range(1, 2)); end
         end
         if (!b_valid && $urandom_range(0, 3) == 0) begin
            b_valid = 1'b1; b_rs = 1'($urandom_range(0, 1)); b_data = 8'($urandom);
         end
      end
      @(posedge clk); #1; a_valid = 1'b0; b_valid = 1'b0;
      wait_for(2, "idle_after_random");

      // reset in the middle of an e pulse
      @(posedge clk); #1; a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h41;
      wait_for(3, "a_ready_pre_reset");
      @(posedge clk); #1; a_valid = 1'b0;
      wait_for(0, "e_before_reset");
      #2 rst = 1'b0;
      #1;
      check("rst_lcd_e", lcd_e, 0);
      check("rst_init_done", init_done, 0);
      check("rst_busy", busy, 1);
      a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h31;
      b_valid = 1'b1; b_rs = 1'b1; b_data = 8'h2B;
      @(negedge clk); @(negedge clk);
      glog.delete();
      #2 rst = 1'b1;
      wait_for(0, "restart_e_rise");
      check("restart_pwr_wait_clks", m_n, (PWR_TICKS + 1) * CLK_DIV);

      // both held continuously: grants alternate starting with A
      begin
         int g = 0;
         while (glog.size() < 4 && g < 3000) begin @(negedge clk); g++; end
      end
      for (int i = 0; i < 4; i++)
         check("grant_order", (i < glog.size()) ? glog[i] : -1, i % 2);
      @(posedge clk); #1; a_valid = 1'b0; b_valid = 1'b0;
      wait_for(2, "idle_after_alternation");

      a_write(1'b0, 8'h01, LONG_EN ? (1 + WAIT_LONG) * CLK_DIV : (1 + WAIT_SHORT) * CLK_DIV);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
